// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexes packed BCD digits onto one decoder with blanking gaps between digits.
// Define LZ_SUPPRESS_EN to keep leading zero digits dark (digit 0 is always shown).
module display_scan_ctrl #(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 8,
    parameter int DIG_ACT_LO = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digits_in,
    output logic [3:0]            bcd,
    output logic [N_DIGITS-1:0]   dig_en,
    output logic                  blank,
    output logic                  frame_done
);
    localparam int IW   = $clog2(N_DIGITS);
    localparam int CMAX = SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [N_DIGITS-1:0] POL = {N_DIGITS{DIG_ACT_LO != 0}};

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] pending_q, pending_d, shadow_q, shadow_d;
    logic [3:0]            bcd_q, bcd_d;
    logic [N_DIGITS-1:0]   dig_en_q, dig_en_d, act_d, lz;
    logic                  blank_q, blank_d, fd_q, fd_d;
`ifdef LZ_SUPPRESS_EN
    logic                  z;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        fd_d      = 1'b0;
        pending_d = load ? digits_in : pending_q;
        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            shadow_d = pending_d;
            idx_d    = '0;
            cnt_d    = '0;
            state_d  = BLANK_CYC == 0 ? SHOW : BLANK;
        end else if (state_q == BLANK) begin
            state_d = cnt_q == CW'(BLANK_CYC - 1) ? SHOW : BLANK;
            cnt_d   = cnt_q == CW'(BLANK_CYC - 1) ? '0 : cnt_q + 1'b1;
        end else if (state_q == SHOW) begin
            if (cnt_q == CW'(SCAN_DIV - 1)) begin
                cnt_d   = '0;
                state_d = BLANK_CYC == 0 ? SHOW : BLANK;
                // frame boundary: swap in the pending value so a frame never tears
                if (idx_q == IW'(N_DIGITS - 1)) begin
                    idx_d    = '0;
                    fd_d     = 1'b1;
                    shadow_d = pending_d;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
        lz = '0;
`ifdef LZ_SUPPRESS_EN
        z = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            z     = z & (shadow_d[4*i +: 4] == 4'h0);
            lz[i] = z;
        end
`endif
        act_d    = (state_d == SHOW && !lz[idx_d]) ? {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_d : '0;
        dig_en_d = act_d ^ POL;
        blank_d  = act_d == '0;
        bcd_d    = state_d == IDLE ? 4'h0 : shadow_d[{idx_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            shadow_q  <= '0;
            bcd_q     <= 4'h0;
            dig_en_q  <= POL;
            blank_q   <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            bcd_q     <= bcd_d;
            dig_en_q  <= dig_en_d;
            blank_q   <= blank_d;
            fd_q      <= fd_d;
        end
    end

    assign bcd        = bcd_q;
    assign dig_en     = dig_en_q;
    assign blank      = blank_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench; expected outputs come from a frame-position arithmetic model.
module tb_display_scan_ctrl;
    localparam int N = 4, S = 4, B = 1, FRAME = N * (B + S);

    logic        clk = 1'b0, rst_n, en, load;
    logic [15:0] digits_in;
    logic [3:0]  bcd, dig_en;
    logic        blank, frame_done;

    always #5 clk = ~clk;

    display_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(S), .BLANK_CYC(B), .DIG_ACT_LO(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
        .bcd(bcd), .dig_en(dig_en), .blank(blank), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [3:0] bcd;
        logic [3:0] dig_en;
        logic       blank;
        logic       fd;
    } exp_t;

    exp_t        q[$];
    int          tests = 0, fails = 0;
    bit          mon_on = 0;
    logic [15:0] pend, shad;
    bit          scanning, fd;
    int          t;

    function automatic bit lead_zero(int slot);
`ifdef LZ_SUPPRESS_EN
        if (slot == 0) return 1'b0;
        for (int i = slot; i < N; i++)
            if (shad[4*i +: 4] != 4'h0) return 1'b0;
        return 1'b1;
`else
        return (slot < 0);
`endif
    endfunction

    // t counts edges since scanning started; position in the frame gives slot and phase
    function automatic exp_t model_out();
        exp_t e;
        int p, slot, w;
        if (!scanning) begin
            e = '{4'h0, 4'hF, 1'b1, 1'b0};
        end else begin
            p        = t % FRAME;
            slot     = p / (B + S);
            w        = p % (B + S);
            e.bcd    = shad[4*slot +: 4];
            e.blank  = !(w >= B && !lead_zero(slot));
            e.dig_en = e.blank ? 4'hF : ~(4'b0001 << slot);
            e.fd     = fd;
        end
        return e;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    task automatic step(bit e_in, bit l_in, logic [15:0] d);
        en        = e_in;
        load      = l_in;
        digits_in = d;
        fd        = 1'b0;
        if (!e_in) begin
            scanning = 1'b0;
        end else if (!scanning) begin
            scanning = 1'b1;
            t        = 0;
            shad     = l_in ? d : pend;
        end else begin
            t++;
            if (t % FRAME == 0) begin
                shad = l_in ? d : pend;
                fd   = 1'b1;
            end
        end
        if (l_in) pend = d;
        q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_show(int slot);
        return scanning && (t % FRAME) / (B + S) == slot && (t % FRAME) % (B + S) >= B;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                e = q.pop_front();
                check("bcd", 32'(bcd), 32'(e.bcd));
                check("dig_en", 32'(dig_en), 32'(e.dig_en));
                check("blank", 32'(blank), 32'(e.blank));
                check("frame_done", 32'(frame_done), 32'(e.fd));
                check("one_hot", 32'($countones(~dig_en) <= 1), 32'd1);
            end
        end
    end

    initial begin
        logic [15:0] d;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = '0;
        pend = '0; shad = '0; scanning = 1'b0; t = 0; fd = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bcd", 32'(bcd), 32'h0);
        check("rst_dig_en", 32'(dig_en), 32'hF);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model_out());
        mon_on = 1'b1;
        step(0, 1, 16'h1234);
        repeat (30) step(1, 0, 16'h0);
        for (int i = 0; i < 2 * FRAME && !in_show(1); i++) step(1, 0, 16'h0);
        step(1, 1, 16'h5678);
        repeat (FRAME + 5) step(1, 0, 16'h0);
        for (int i = 0; i < FRAME && (t + 1) % FRAME != 0; i++) step(1, 0, 16'h0);
        step(1, 1, 16'h9999);
        repeat (FRAME + 2) step(1, 0, 16'h0);
        for (int i = 0; i < 2 * FRAME && !in_show(2); i++) step(1, 0, 16'h0);
        step(0, 0, 16'h0);
        step(0, 0, 16'h0);
        repeat (FRAME + 5) step(1, 0, 16'h0);
        step(1, 1, 16'h0070);
        repeat (2 * FRAME) step(1, 0, 16'h0);
        step(1, 1, 16'h0000);
        repeat (2 * FRAME) step(1, 0, 16'h0);
        repeat (1500) begin
            d = 16'($urandom);
            d = d & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            step($urandom_range(0, 39) != 0, $urandom_range(0, 7) == 0, d);
        end
        for (int i = 0; i < 2 * FRAME && !in_show(1); i++) step(1, 0, 16'h0);
        @(negedge clk);
        #1;
        mon_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_bcd", 32'(bcd), 32'h0);
        check("async_rst_dig_en", 32'(dig_en), 32'hF);
        check("async_rst_blank", 32'(blank), 32'h1);
        check("async_rst_frame_done", 32'(frame_done), 32'h0);
        q.delete();
        pend = '0; shad = '0; scanning = 1'b0; fd = 1'b0;
        en = 1'b0; load = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.push_back(model_out());
        mon_on = 1'b1;
        repeat (3 * FRAME) step(1, 0, 16'h0);
        @(negedge clk);
        #1;
        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
